// File: rtl/pdp1_sbr_pkg.sv
// Shared definitions for the PDP-1 sequence-break responder: FSM state
// encodings, save-area offsets and the packing of the saved PC/status word.
package pdp1_sbr_pkg;

    // Break-cycle sequencer states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AC   = 3'd1,
        S_PC   = 3'd2,
        S_IO   = 3'd3,
        S_JMP  = 3'd4
    } sbr_state_e;

    // Offsets from the save-area base
    localparam logic [0:11] OFF_AC  = 12'd0;
    localparam logic [0:11] OFF_PC  = 12'd1;
    localparam logic [0:11] OFF_IO  = 12'd2;
    localparam logic [0:11] OFF_VEC = 12'd3;

    // Saved PC word: bit 0 = overflow, bit 1 = extend, bits 6..17 = PC
    function automatic logic [0:17] pc_word(input logic ov, input logic ex,
                                            input logic [0:11] pc);
        return {ov, ex, 4'b0000, pc};
    endfunction

endpackage

// File: rtl/pdp1_sbr.sv
// CPU-side sequence-break responder. On a break request at an instruction
// boundary it stalls the CPU, stores AC, PC/status and IO into the save
// area, loads the PC with the break vector and tracks break-in-progress
// until the CPU reports the return jump.
module pdp1_sbr
    import pdp1_sbr_pkg::*;
#(
    parameter logic [0:11] P_BASE = 12'o0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        sb_ireq,
    output logic        sb_dne,
    output logic        sb_bip,
    input  logic        cpu_ibnd,
    output logic        cpu_hold,
    input  logic        cpu_ret,
    input  logic [0:17] cpu_ac,
    input  logic [0:17] cpu_io,
    input  logic [0:11] cpu_pc,
    input  logic        cpu_ov,
    input  logic        cpu_ex,
    output logic        cpu_pc_ld,
    output logic [0:11] cpu_pc_new,
    output logic        mm_we,
    output logic [0:11] mm_adr,
    output logic [0:17] mm_dout,
    input  logic        mm_ack
);

    sbr_state_e  state_q, state_d;
    logic        bip_q, bip_d;
    logic [0:17] ac_q, io_q;
    logic [0:11] pc_q;
    logic        ov_q, ex_q;
    logic        accept_s;

    // A break is taken only from idle, at a boundary, with no break active
    assign accept_s = (state_q == S_IDLE) & sb_ireq & cpu_ibnd & ~bip_q;
    assign sb_bip   = bip_q;

    // Next-state and break-in-progress logic
    always_comb begin
        state_d = state_q;
        // A return clears the flag; it is already clear outside idle
        if (cpu_ret) begin
            bip_d = 1'b0;
        end else begin
            bip_d = bip_q;
        end
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_AC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AC: begin
                if (mm_ack) begin
                    state_d = S_PC;
                end else begin
                    state_d = S_AC;
                end
            end
            S_PC: begin
                if (mm_ack) begin
                    state_d = S_IO;
                end else begin
                    state_d = S_PC;
                end
            end
            S_IO: begin
                if (mm_ack) begin
                    state_d = S_JMP;
                end else begin
                    state_d = S_IO;
                end
            end
            S_JMP: begin
                state_d = S_IDLE;
                bip_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                bip_d   = 1'b0;
            end
        endcase
    end

    // Sequencer state and break-in-progress flag registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            bip_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bip_q   <= bip_d;
        end
    end

    // Snapshot of CPU state at acceptance; deliberately survives reset
    always_ff @(posedge i_clk) begin
        if (accept_s && !i_rst) begin
            ac_q <= cpu_ac;
            io_q <= cpu_io;
            pc_q <= cpu_pc;
            ov_q <= cpu_ov;
            ex_q <= cpu_ex;
        end else begin
            ac_q <= ac_q;
            io_q <= io_q;
            pc_q <= pc_q;
            ov_q <= ov_q;
            ex_q <= ex_q;
        end
    end

    // Output decode from state and snapshot; adr/data stay fixed while a write waits
    always_comb begin
        mm_we      = 1'b0;
        mm_adr     = 12'd0;
        mm_dout    = 18'd0;
        cpu_hold   = 1'b0;
        cpu_pc_ld  = 1'b0;
        cpu_pc_new = 12'd0;
        sb_dne     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cpu_hold = 1'b0;
            end
            S_AC: begin
                cpu_hold = 1'b1;
                mm_we    = 1'b1;
                mm_adr   = P_BASE + OFF_AC;
                mm_dout  = ac_q;
            end
            S_PC: begin
                cpu_hold = 1'b1;
                mm_we    = 1'b1;
                mm_adr   = P_BASE + OFF_PC;
                mm_dout  = pc_word(ov_q, ex_q, pc_q);
            end
            S_IO: begin
                cpu_hold = 1'b1;
                mm_we    = 1'b1;
                mm_adr   = P_BASE + OFF_IO;
                mm_dout  = io_q;
            end
            S_JMP: begin
                cpu_hold   = 1'b1;
                cpu_pc_ld  = 1'b1;
                cpu_pc_new = P_BASE + OFF_VEC;
                sb_dne     = 1'b1;
            end
            default: begin
                cpu_hold = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pdp1_sbr.sv
// Bench for pdp1_sbr: two instances (base 0 and base 7776 octal) share the
// same stimulus; a queue-based transaction model predicts every output each
// cycle, and directed sequences pin timing and memory contents with literals.
module tb_pdp1_sbr;

    logic        clk;
    logic        rst, ireq, ibnd, ret, ack, ov, ex;
    logic [0:17] ac, io;
    logic [0:11] pc;

    logic [1:0]  dne, bip, hold, pc_ld, we;
    logic [0:11] pc_new [2];
    logic [0:11] adr    [2];
    logic [0:17] dout   [2];

    logic [11:0] base [2];
    logic [17:0] mem  [2][4096];

    // transaction model: outstanding save writes, then one vector jump
    logic [11:0] off_q [$];
    logic [17:0] dat_q [$];
    bit          jmp_pend;
    bit          mbip;

    int vectors, errors, cyc;
    int dne_cnt, dne_cyc, hold_cnt, t0;
    logic [11:0] pcnew_at_dne [2];

    pdp1_sbr #(.P_BASE(12'o0000)) dut0 (
        .i_clk(clk), .i_rst(rst), .sb_ireq(ireq), .sb_dne(dne[0]), .sb_bip(bip[0]),
        .cpu_ibnd(ibnd), .cpu_hold(hold[0]), .cpu_ret(ret), .cpu_ac(ac), .cpu_io(io),
        .cpu_pc(pc), .cpu_ov(ov), .cpu_ex(ex), .cpu_pc_ld(pc_ld[0]), .cpu_pc_new(pc_new[0]),
        .mm_we(we[0]), .mm_adr(adr[0]), .mm_dout(dout[0]), .mm_ack(ack)
    );

    pdp1_sbr #(.P_BASE(12'o7776)) dut1 (
        .i_clk(clk), .i_rst(rst), .sb_ireq(ireq), .sb_dne(dne[1]), .sb_bip(bip[1]),
        .cpu_ibnd(ibnd), .cpu_hold(hold[1]), .cpu_ret(ret), .cpu_ac(ac), .cpu_io(io),
        .cpu_pc(pc), .cpu_ov(ov), .cpu_ex(ex), .cpu_pc_ld(pc_ld[1]), .cpu_pc_new(pc_new[1]),
        .mm_we(we[1]), .mm_adr(adr[1]), .mm_dout(dout[1]), .mm_ack(ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare outputs to the model, update memory and model, advance
    task automatic tick();
        bit          busy, e_we, e_jmp;
        logic [11:0] e_adr, e_vec;
        logic [17:0] e_dat;
        bit          acc;
        busy  = (off_q.size() > 0) || jmp_pend;
        e_we  = (off_q.size() > 0);
        e_jmp = jmp_pend && (off_q.size() == 0);
        for (int k = 0; k < 2; k++) begin
            e_adr = e_we ? 12'(base[k] + off_q[0]) : 12'd0;
            e_dat = e_we ? dat_q[0] : 18'd0;
            e_vec = e_jmp ? 12'(base[k] + 12'd3) : 12'd0;
            chk($sformatf("hold%0d", k),   {31'd0, hold[k]},  {31'd0, busy});
            chk($sformatf("we%0d", k),     {31'd0, we[k]},    {31'd0, e_we});
            chk($sformatf("adr%0d", k),    {20'd0, adr[k]},   {20'd0, e_adr});
            chk($sformatf("dout%0d", k),   {14'd0, dout[k]},  {14'd0, e_dat});
            chk($sformatf("pcld%0d", k),   {31'd0, pc_ld[k]}, {31'd0, e_jmp});
            chk($sformatf("pcnew%0d", k),  {20'd0, pc_new[k]}, {20'd0, e_vec});
            chk($sformatf("dne%0d", k),    {31'd0, dne[k]},   {31'd0, e_jmp});
            chk($sformatf("bip%0d", k),    {31'd0, bip[k]},   {31'd0, mbip});
            if (we[k] && ack) mem[k][adr[k]] = dout[k];
            if (dne[k]) pcnew_at_dne[k] = pc_new[k];
        end
        if (dne[0]) begin
            dne_cnt++;
            dne_cyc = cyc;
        end
        if (hold[0]) hold_cnt++;
        // model update for the coming edge
        if (rst) begin
            off_q.delete();
            dat_q.delete();
            jmp_pend = 0;
            mbip     = 0;
        end else if (off_q.size() > 0) begin
            if (ack) begin
                void'(off_q.pop_front());
                void'(dat_q.pop_front());
            end
        end else if (jmp_pend) begin
            jmp_pend = 0;
            mbip     = 1;
        end else begin
            acc = ireq && ibnd && !mbip;
            if (ret) mbip = 0;
            if (acc) begin
                off_q.push_back(12'd0); dat_q.push_back(ac);
                off_q.push_back(12'd1);
                dat_q.push_back((ov ? 18'o400000 : 18'd0) | (ex ? 18'o200000 : 18'd0) | 18'(pc));
                off_q.push_back(12'd2); dat_q.push_back(io);
                jmp_pend = 1;
            end
        end
        vectors++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0; errors = 0; cyc = 0;
        dne_cnt = 0; dne_cyc = 0; hold_cnt = 0; t0 = 0;
        jmp_pend = 0; mbip = 0;
        base[0] = 12'o0000; base[1] = 12'o7776;
        pcnew_at_dne[0] = 12'd0; pcnew_at_dne[1] = 12'd0;
        rst = 1; ireq = 0; ibnd = 0; ret = 0; ack = 1; ov = 0; ex = 0;
        ac = 18'd0; io = 18'd0; pc = 12'd0;
        @(posedge clk);
        #1;
        tick(); tick();
        rst = 0;
        tick();
        chk("reset_hold", {31'd0, hold[0]}, 32'd0);
        chk("reset_bip",  {31'd0, bip[0]},  32'd0);
        chk("reset_we",   {31'd0, we[1]},   32'd0);

        // basic break, zero-wait memory
        ac = 18'o123456; io = 18'o654321; pc = 12'o0750; ov = 1; ex = 0;
        ireq = 1; ibnd = 1; dne_cnt = 0; t0 = cyc;
        tick();
        ireq = 0; ibnd = 0;
        repeat (6) tick();
        chk("basic_latency", dne_cyc - t0, 32'd4);
        chk("basic_dne_cnt", dne_cnt, 32'd1);
        chk("basic_mem_ac", {14'd0, mem[0][0]}, 32'o123456);
        chk("basic_mem_pc", {14'd0, mem[0][1]}, 32'o400750);
        chk("basic_mem_io", {14'd0, mem[0][2]}, 32'o654321);
        chk("basic_vec0",   {20'd0, pcnew_at_dne[0]}, 32'o0003);
        chk("wrap_mem_ac",  {14'd0, mem[1][12'o7776]}, 32'o123456);
        chk("wrap_mem_pc",  {14'd0, mem[1][12'o7777]}, 32'o400750);
        chk("wrap_mem_io",  {14'd0, mem[1][12'o0000]}, 32'o654321);
        chk("wrap_vec1",    {20'd0, pcnew_at_dne[1]}, 32'o0001);
        chk("basic_bip",    {31'd0, bip[0]}, 32'd1);

        // memory wait states: ack on every third cycle
        ret = 1; tick(); ret = 0;
        ac = 18'(  $urandom); io = 18'($urandom); pc = 12'($urandom); ov = 0; ex = 1;
        ireq = 1; ibnd = 1; ack = 0; hold_cnt = 0; dne_cnt = 0; t0 = cyc;
        tick();
        ireq = 0; ibnd = 0;
        for (int i = 1; i <= 12; i++) begin
            ack = (i % 3 == 0);
            tick();
        end
        ack = 1;
        chk("wait_latency", dne_cyc - t0, 32'd10);
        chk("wait_hold",    hold_cnt, 32'd10);
        chk("wait_dne_cnt", dne_cnt, 32'd1);

        // request blocked while break in progress, then same-cycle return
        ireq = 1; ibnd = 1; hold_cnt = 0;
        repeat (3) tick();
        chk("blocked_hold", hold_cnt, 32'd0);
        ret = 1;
        tick();
        ret = 0;
        chk("ret_same_hold", {31'd0, hold[0]}, 32'd0);
        chk("ret_same_bip",  {31'd0, bip[0]},  32'd0);
        dne_cnt = 0;
        tick();
        chk("accept_next_hold", {31'd0, hold[0]}, 32'd1);
        tick();
        ireq = 0; ibnd = 0;
        repeat (6) tick();
        chk("drop_dne_cnt", dne_cnt, 32'd1);

        // no boundary, then reset in S_PC
        ret = 1; tick(); ret = 0;
        ireq = 1; ibnd = 0; hold_cnt = 0;
        repeat (3) tick();
        chk("nobnd_hold", hold_cnt, 32'd0);
        ibnd = 1;
        tick();
        ireq = 0; ibnd = 0;
        tick();
        chk("pre_rst_we", {31'd0, we[0]}, 32'd1);
        rst = 1; dne_cnt = 0;
        tick();
        rst = 0;
        chk("rst_we",   {31'd0, we[0]},   32'd0);
        chk("rst_hold", {31'd0, hold[0]}, 32'd0);
        chk("rst_bip",  {31'd0, bip[0]},  32'd0);
        repeat (4) tick();
        chk("rst_dne_cnt", dne_cnt, 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(63) == 0);
            ireq = $urandom_range(1);
            ibnd = $urandom_range(1);
            ret  = ($urandom_range(7) == 0);
            ack  = ($urandom_range(9) < 6);
            ov   = $urandom_range(1);
            ex   = $urandom_range(1);
            ac   = 18'($urandom);
            io   = 18'($urandom);
            pc   = 12'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
